// File: rtl/instr_fetch.sv
// Instruction fetch stage: writable instruction memory, program counter and a
// run/single-step sequencer. Issues one registered word per advance and stops
// on a HALT opcode.
module instr_fetch #(
   parameter int              ADDR_W   = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [5:0]      HALT_OP  = 6'h3F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [31:0]       ld_data,
   input  logic              start,
   input  logic              run,
   input  logic              step,
   input  logic              stall,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic [ADDR_W-1:0] pc_out,
   output logic              halted
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [ADDR_W-1:0] pc_out_q, pc_out_d;
   logic [31:0]       instr_q, instr_d;
   logic              valid_q, valid_d;
   logic              halted_q, halted_d;
   logic              step_q, step_d;

   logic [31:0]       mem_q [DEPTH];
   logic [31:0]       rd_word;
   logic              mem_we;
   logic              adv;

   // Combinational read at the current pc; the fetch register is the only stage.
   always_comb begin
      rd_word = mem_q[pc_q];
      mem_we  = (state_q == IDLE) & ld_we & ~rst;
      step_d  = step;
      adv     = (state_q == FETCH) & ~stall & (run | (step & ~step_q));
   end

   // Next-state and fetch-register updates; everything holds unless told otherwise.
   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      pc_out_d = pc_out_q;
      instr_d  = instr_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      case (state_q)
         IDLE: begin
            valid_d = 1'b0;
            if (start) state_d = FETCH;
         end
         FETCH: begin
            if (!stall) begin
               valid_d = 1'b0;
               if (adv) begin
                  pc_out_d = pc_q;
                  if (rd_word[31:26] == HALT_OP) begin
                     // The HALT word is consumed but never issued downstream.
                     instr_d  = '0;
                     halted_d = 1'b1;
                     state_d  = HALT;
                  end else begin
                     instr_d = rd_word;
                     valid_d = 1'b1;
                     pc_d    = pc_q + ADDR_W'(1);
                  end
               end
            end
         end
         default: ;
      endcase
   end

   // State registers; reset leaves the instruction memory untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         pc_out_q <= '0;
         instr_q  <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         step_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         pc_out_q <= pc_out_d;
         instr_q  <= instr_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         step_q   <= step_d;
      end
   end

   // Program load port, only open while idle.
   always_ff @(posedge clk) begin
      if (mem_we) mem_q[ld_addr] <= ld_data;
   end

   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign pc_out      = pc_out_q;
   assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_instr_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_we = 1'b0;
   logic [3:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        start = 1'b0, run = 1'b0, step = 1'b0, stall = 1'b0;
   logic [31:0] instr;
   logic        instr_valid;
   logic [3:0]  pc_out;
   logic        halted;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   instr_fetch #(.ADDR_W(4), .RESET_PC(4'd0), .HALT_OP(6'h3F)) dut (
      .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
      .start(start), .run(run), .step(step), .stall(stall),
      .instr(instr), .instr_valid(instr_valid), .pc_out(pc_out), .halted(halted)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // mode: 0 = idle, 1 = fetching, 2 = halted
   int          m_mode = 0;
   logic [31:0] m_mem [16];
   int          m_pc = 0;
   bit          m_prev_step = 0;
   logic [31:0] e_instr = '0;
   bit          e_valid = 0;
   int          e_pc = 0;
   bit          e_halt = 0;

   initial for (int i = 0; i < 16; i++) m_mem[i] = '0;

   always @(posedge clk) begin
      bit edge_seen;
      logic [31:0] w;
      edge_seen = step && !m_prev_step;
      if (rst) begin
         m_mode = 0; m_pc = 0; e_instr = '0; e_valid = 0; e_pc = 0; e_halt = 0;
         m_prev_step = 0;
      end else begin
         if (m_mode == 0) begin
            if (ld_we) m_mem[ld_addr] = ld_data;
            e_valid = 0;
            if (start) m_mode = 1;
         end else if (m_mode == 1 && !stall) begin
            e_valid = 0;
            if (run || edge_seen) begin
               w = m_mem[m_pc];
               e_pc = m_pc;
               if (w[31:26] == 6'h3F) begin
                  e_instr = '0; e_halt = 1; m_mode = 2;
               end else begin
                  e_instr = w; e_valid = 1; m_pc = (m_pc + 1) % 16;
               end
            end
         end
         m_prev_step = step;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Single compare process against the model.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_instr", instr, e_instr);
         chk("model_valid", {31'd0, instr_valid}, {31'd0, e_valid});
         chk("model_pc_out", {28'd0, pc_out}, e_pc[31:0]);
         chk("model_halted", {31'd0, halted}, {31'd0, e_halt});
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic load(input int a, input logic [31:0] d);
      ld_we = 1'b1; ld_addr = 4'(a); ld_data = d;
      tick();
      ld_we = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1; tick(); rst = 1'b0;
   endtask

   task automatic go(input bit r);
      run = r; start = 1'b1; tick(); start = 1'b0;
   endtask

   int nvalid;
   int wait_n;
   logic [31:0] held_instr;
   logic [3:0]  held_pc;

   initial begin
      // Reset with random other inputs for two cycles.
      tick();
      for (int i = 0; i < 2; i++) begin
         ld_we = 1'($urandom); ld_addr = 4'($urandom); ld_data = $urandom;
         start = 1'($urandom); run = 1'($urandom); step = 1'($urandom); stall = 1'($urandom);
         tick();
      end
      chk_en = 1'b1;
      chk("rst_instr", instr, 32'h0);
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_pc_out", {28'd0, pc_out}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      ld_we = 0; start = 0; run = 0; step = 0; stall = 0;
      rst = 1'b0;

      // Sixteen non-HALT words: pc must wrap 15 -> 0.
      for (int i = 0; i < 16; i++) load(i, 32'h0);
      go(1'b1);
      for (int k = 0; k < 17; k++) begin
         tick();
         chk("wrap_valid", {31'd0, instr_valid}, 32'd1);
         chk("wrap_pc", {28'd0, pc_out}, k % 16);
      end
      chk("wrap_halted", {31'd0, halted}, 32'd0);

      // Load attempt while fetching must be ignored.
      load(0, 32'hDEADBEEF);
      wait_n = 0;
      do begin tick(); wait_n++; end while (pc_out != 4'd0 && wait_n < 20);
      chk("ldfetch_pc0_seen", {31'd0, pc_out == 4'd0}, 32'd1);
      chk("ldfetch_word", instr, 32'h0);

      // Reset mid-run returns to idle.
      do_reset();
      chk("midrst_valid", {31'd0, instr_valid}, 32'd0);
      chk("midrst_pc", {28'd0, pc_out}, 32'd0);
      tick();
      chk("midrst_idle_valid", {31'd0, instr_valid}, 32'd0);

      // LW / SW / HALT program, free-running.
      load(0, 32'h54010005); load(1, 32'h50020002); load(2, 32'hFC000000);
      go(1'b1);
      tick(); chk("run_w0", instr, 32'h54010005); chk("run_pc0", {28'd0, pc_out}, 32'd0);
      chk("run_v0", {31'd0, instr_valid}, 32'd1);
      tick(); chk("run_w1", instr, 32'h50020002); chk("run_pc1", {28'd0, pc_out}, 32'd1);
      tick(); chk("run_halt_v", {31'd0, instr_valid}, 32'd0);
      chk("run_halted", {31'd0, halted}, 32'd1); chk("run_halt_pc", {28'd0, pc_out}, 32'd2);
      // HALT ignores start/step/ld_we.
      start = 1; step = 1; ld_we = 1; ld_addr = 0; ld_data = 32'h1234; tick(); tick();
      start = 0; step = 0; ld_we = 0;
      chk("halt_frozen", {31'd0, halted}, 32'd1);

      // Single-step mode with the retained program.
      do_reset();
      go(1'b0);
      nvalid = 0;
      step = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (instr_valid) begin nvalid++; chk("step_w0", instr, 32'h54010005); end
      end
      chk("step_hold_count", nvalid, 32'd1);
      step = 1'b0; nvalid = 0;
      for (int i = 0; i < 3; i++) begin tick(); if (instr_valid) nvalid++; end
      chk("step_gap_count", nvalid, 32'd0);
      step = 1'b1; tick();
      chk("step_w1", instr, 32'h50020002); chk("step_v1", {31'd0, instr_valid}, 32'd1);
      step = 1'b0;

      // Stall while the SW word is valid.
      do_reset();
      go(1'b1);
      tick(); tick();
      chk("stall_pre", instr, 32'h50020002);
      stall = 1'b1;
      held_instr = instr; held_pc = pc_out;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_instr", instr, 32'h50020002);
         chk("stall_valid", {31'd0, instr_valid}, 32'd1);
         chk("stall_pc", {28'd0, pc_out}, 32'd1);
      end
      stall = 1'b0; tick();
      chk("stall_release_halt", {31'd0, halted}, 32'd1);

      // Randomized traffic against the model.
      do_reset();
      for (int i = 0; i < 16; i++)
         load(i, ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)} : {6'($urandom_range(0, 62)), 26'($urandom)});
      for (int c = 0; c < 4000; c++) begin
         rst     = ($urandom_range(0, 63) == 0);
         start   = ($urandom_range(0, 3) == 0);
         run     = 1'($urandom);
         if ($urandom_range(0, 2) == 0) step = ~step;
         stall   = ($urandom_range(0, 3) == 0);
         ld_we   = ($urandom_range(0, 2) == 0);
         ld_addr = 4'($urandom);
         ld_data = ($urandom_range(0, 7) == 0) ? {6'h3F, 26'($urandom)} : {6'($urandom_range(0, 62)), 26'($urandom)};
         tick();
      end
      rst = 0; ld_we = 0; start = 0; stall = 0;
      tick();
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
